// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX operand register stage feeding the EX-stage ALU
// Ports: clk, rst_n (synchronous, active-low); in_valid/in_ready and in_* decode fields;
//   flush kills the held and the incoming instruction; exm_*/mwb_* bypass sources;
//   out_valid/out_ready EX handshake; alu_in_1/alu_in_2/alu_op drive the ALU;
//   out_rd/out_reg_write pass through to EX/MEM; stall_cnt counts stalled cycles (saturating).
// Option: define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding plus operand
//   refresh while held; otherwise the bypass inputs are ignored and held operands stay static.
module id_ex_operand_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_rs_data,
    input  logic [WIDTH-1:0]    in_rt_data,
    input  logic [WIDTH-1:0]    in_imm,
    input  logic [REG_AW-1:0]   in_rs,
    input  logic [REG_AW-1:0]   in_rt,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic [3:0]          in_alu_op,
    input  logic                in_use_imm,
    input  logic                in_reg_write,
    input  logic                flush,
    input  logic                exm_wr,
    input  logic [REG_AW-1:0]   exm_rd,
    input  logic [WIDTH-1:0]    exm_res,
    input  logic                mwb_wr,
    input  logic [REG_AW-1:0]   mwb_rd,
    input  logic [WIDTH-1:0]    mwb_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_in_1,
    output logic [WIDTH-1:0]    alu_in_2,
    output logic [3:0]          alu_op,
    output logic [REG_AW-1:0]   out_rd,
    output logic                out_reg_write,
    output logic [STALL_CW-1:0] stall_cnt
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    logic [REG_AW-1:0] rs_q, rt_q;
    logic [WIDTH-1:0]  rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
    logic              use_imm_q, capture, hold;
`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer so it wins; $zero is never bypassed
    always_comb begin
        fwd_rs = exm_wr && exm_rd == rs_q && rs_q != '0 ? exm_res :
                 mwb_wr && mwb_rd == rs_q && rs_q != '0 ? mwb_res : rs_data_q;
        fwd_rt = exm_wr && exm_rd == rt_q && rt_q != '0 ? exm_res :
                 mwb_wr && mwb_rd == rt_q && rt_q != '0 ? mwb_res : rt_data_q;
    end
`else
    logic unused_bypass;
    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
    assign unused_bypass = ^{exm_wr, exm_rd, exm_res, mwb_wr, mwb_rd, mwb_res, rs_q, rt_q};
`endif
    assign in_ready = !out_valid || out_ready || flush;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = out_valid && !out_ready;
    assign alu_in_1 = fwd_rs;
    assign alu_in_2 = use_imm_q ? imm_q : fwd_rt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            use_imm_q     <= 1'b0;
            alu_op        <= ALU_ADD;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            out_valid <= flush ? 1'b0 : capture ? 1'b1 : hold;
            if (capture) begin
                rs_q          <= in_rs;
                rt_q          <= in_rt;
                rs_data_q     <= in_rs_data;
                rt_data_q     <= in_rt_data;
                imm_q         <= in_imm;
                use_imm_q     <= in_use_imm;
                alu_op        <= in_alu_op;
                out_rd        <= in_rd;
                out_reg_write <= in_reg_write;
            end else if (hold) begin
                // latch bypassed values so they survive the producer retiring mid-stall
                rs_data_q <= fwd_rs;
                rt_data_q <= fwd_rt;
            end
            if (hold && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CW'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
    localparam int W = 32;
    localparam int A = 5;
    localparam int SCW = 4;
    localparam int SMAX = (1 << SCW) - 1;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct packed {
        logic [A-1:0] rs, rt, rd;
        logic [W-1:0] rs_data, rt_data, imm;
        logic [3:0]   op;
        logic         use_imm, rw;
    } instr_t;

    logic clk, rst_n, in_valid, in_ready, in_use_imm, in_reg_write, flush;
    logic [W-1:0] in_rs_data, in_rt_data, in_imm, exm_res, mwb_res, alu_in_1, alu_in_2;
    logic [A-1:0] in_rs, in_rt, in_rd, exm_rd, mwb_rd, out_rd;
    logic [3:0] in_alu_op, alu_op;
    logic exm_wr, mwb_wr, out_valid, out_ready, out_reg_write;
    logic [SCW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    instr_t m;
    bit m_valid = 0;
    int m_stall = 0;

    id_ex_operand_stage #(.WIDTH(W), .REG_AW(A), .STALL_CW(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write), .flush(flush),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res),
        .out_valid(out_valid), .out_ready(out_ready), .alu_in_1(alu_in_1),
        .alu_in_2(alu_in_2), .alu_op(alu_op), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_fwd(input logic [A-1:0] r, input logic [W-1:0] d);
        if (FWD && r != 0 && exm_wr && exm_rd == r) return exm_res;
        if (FWD && r != 0 && mwb_wr && mwb_rd == r) return mwb_res;
        return d;
    endfunction

    function automatic logic [W-1:0] exp_in_1();
        return ref_fwd(m.rs, m.rs_data);
    endfunction

    function automatic logic [W-1:0] exp_in_2();
        return m.use_imm ? m.imm : ref_fwd(m.rt, m.rt_data);
    endfunction

    // reference behaviour for one rising edge, from the handshake rules
    task automatic model_clock();
        bit rdy;
        rdy = !m_valid || out_ready || flush;
        if (!rst_n) begin
            m_valid = 0;
            m_stall = 0;
            m = '0;
        end else begin
            if (m_valid && !out_ready) m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m = '{rs: in_rs, rt: in_rt, rd: in_rd, rs_data: in_rs_data, rt_data: in_rt_data,
                      imm: in_imm, op: in_alu_op, use_imm: in_use_imm, rw: in_reg_write};
                m_valid = 1;
            end else if (m_valid && !out_ready) begin
                m.rs_data = ref_fwd(m.rs, m.rs_data);
                m.rt_data = ref_fwd(m.rt, m.rt_data);
            end else m_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1; in_use_imm = 0; in_reg_write = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_alu_op = 0; exm_wr = 0; exm_rd = 0; exm_res = 0; mwb_wr = 0; mwb_rd = 0; mwb_res = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 0;
        in_valid = 1;
        in_rs_data = 32'h1234;
        do_reset();
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL reset_alu_op got %h exp 0", alu_op); end
        checks++; if (alu_in_1 !== '0) begin errors++; $display("FAIL reset_in_1 got %h exp 0", alu_in_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        idle();
        in_valid = 1; in_rs = 1; in_rt = 2; in_rd = 9; in_rs_data = 5; in_rt_data = 7;
        in_alu_op = 4'd0; in_reg_write = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (alu_in_1 !== 32'd5) begin errors++; $display("FAIL basic_in_1 got %0d exp 5", alu_in_1); end
        checks++; if (alu_in_2 !== 32'd7) begin errors++; $display("FAIL basic_in_2 got %0d exp 7", alu_in_2); end
        checks++; if (out_rd !== 5'd9 || out_reg_write !== 1'b1) begin errors++; $display("FAIL basic_rd got %0d/%b exp 9/1", out_rd, out_reg_write); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b exp 0", out_valid); end
    endtask

    task automatic test_imm();
        idle();
        in_valid = 1; in_rs = 1; in_rt = 2; in_rs_data = 8; in_rt_data = 55;
        in_use_imm = 1; in_imm = 32'hFFFF_FFFC; in_alu_op = 4'd3;
        tick();
        in_valid = 0;
        #1;
        checks++; if (alu_in_2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_in_2 got %h exp fffffffc", alu_in_2); end
        checks++; if (alu_in_1 !== 32'd8) begin errors++; $display("FAIL imm_in_1 got %0d exp 8", alu_in_1); end
        checks++; if (alu_op !== 4'd3) begin errors++; $display("FAIL imm_alu_op got %h exp 3", alu_op); end
        tick();
    endtask

    task automatic test_forward();
        idle();
        in_valid = 1; in_rs = 3; in_rt = 1; in_rs_data = 11; in_rt_data = 12;
        tick();
        in_valid = 0; out_ready = 0;
        exm_wr = 1; exm_rd = 3; exm_res = 100; mwb_wr = 1; mwb_rd = 3; mwb_res = 200;
        #1;
        checks++; if (alu_in_1 !== (FWD ? 32'd100 : 32'd11)) begin errors++; $display("FAIL fwd_exm got %0d exp %0d", alu_in_1, FWD ? 100 : 11); end
        exm_wr = 0;
        #1;
        checks++; if (alu_in_1 !== (FWD ? 32'd200 : 32'd11)) begin errors++; $display("FAIL fwd_mwb got %0d exp %0d", alu_in_1, FWD ? 200 : 11); end
        mwb_wr = 0; out_ready = 1;
        in_valid = 1; in_rs = 0; in_rs_data = 33;
        tick();
        in_valid = 0; out_ready = 0;
        exm_wr = 1; exm_rd = 0; mwb_wr = 1; mwb_rd = 0;
        #1;
        checks++; if (alu_in_1 !== 32'd33) begin errors++; $display("FAIL fwd_zero got %0d exp 33", alu_in_1); end
        idle();
        tick();
    endtask

    task automatic test_hold_refresh();
        idle();
        do_reset();
        in_valid = 1; in_rs = 1; in_rt = 4; in_rs_data = 2; in_rt_data = 9;
        tick();
        in_valid = 0; out_ready = 0;
        exm_wr = 1; exm_rd = 4; exm_res = 42;
        tick();
        exm_wr = 0;
        tick();
        tick();
        out_ready = 1;
        #1;
        checks++; if (alu_in_2 !== (FWD ? 32'd42 : 32'd9)) begin errors++; $display("FAIL refresh_in_2 got %0d exp %0d", alu_in_2, FWD ? 42 : 9); end
        checks++; if (stall_cnt !== SCW'(3)) begin errors++; $display("FAIL refresh_stall got %0d exp 3", stall_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL refresh_valid got %b exp 1", out_valid); end
        tick();
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1; in_rs_data = 77;
        tick();
        out_ready = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_ready got %b exp 0", in_ready); end
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            in_valid = (k < 4);
            in_rs_data = 100 + k;
            in_rd = A'(k);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, in_ready); end
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1 || alu_in_1 !== W'(100 + k - 1)) begin errors++; $display("FAIL b2b_out[%0d] got %b/%0d exp 1/%0d", k, out_valid, alu_in_1, 100 + k - 1); end
            end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stall_saturate();
        idle();
        do_reset();
        in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        repeat (SMAX + 5) tick();
        #1;
        checks++; if (stall_cnt !== SCW'(SMAX)) begin errors++; $display("FAIL sat_stall got %0d exp %0d", stall_cnt, SMAX); end
        do_reset();
        #1;
        checks++; if (stall_cnt !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_reset got %0d/%b exp 0/0", stall_cnt, out_valid); end
        idle();
    endtask

    task automatic test_random();
        idle();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom % 64) != 0;
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 16) == 0;
            in_rs = A'($urandom % 4); in_rt = A'($urandom % 4); in_rd = A'($urandom);
            in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
            in_alu_op = 4'($urandom); in_use_imm = $urandom % 2; in_reg_write = $urandom % 2;
            exm_wr = $urandom % 2; exm_rd = A'($urandom % 4); exm_res = $urandom;
            mwb_wr = $urandom % 2; mwb_rd = A'($urandom % 4); mwb_res = $urandom;
            #1;
            checks++; if (in_ready !== (!m_valid || out_ready || flush)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, in_ready, !m_valid || out_ready || flush); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, m_valid); end
            checks++; if (stall_cnt !== SCW'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", c, stall_cnt, m_stall); end
            if (m_valid) begin
                checks++; if (alu_in_1 !== exp_in_1()) begin errors++; $display("FAIL rnd_in_1[%0d] got %h exp %h", c, alu_in_1, exp_in_1()); end
                checks++; if (alu_in_2 !== exp_in_2()) begin errors++; $display("FAIL rnd_in_2[%0d] got %h exp %h", c, alu_in_2, exp_in_2()); end
                checks++; if (alu_op !== m.op || out_rd !== m.rd || out_reg_write !== m.rw) begin errors++; $display("FAIL rnd_fields[%0d] got %h/%0d/%b exp %h/%0d/%b", c, alu_op, out_rd, out_reg_write, m.op, m.rd, m.rw); end
            end
            tick();
        end
        idle();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_basic();
        test_imm();
        test_forward();
        test_hold_refresh();
        test_flush();
        test_back_to_back();
        test_stall_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
